// File: rtl/uart_pkg.sv
// Shared UART definitions: feeder FSM state encoding and frame timing constants
// used by uart_tx, uart_rx, the feeder and the benches.
package uart_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2
  } tx_feeder_state_t;

  localparam int FRAME_BITS      = 10;
  // uart_tx needs one extra cycle beyond the frame bits to return its DONE pulse.
  localparam int TX_FRAME_CYCLES = FRAME_BITS + 1;

  function automatic logic feeder_active(input tx_feeder_state_t s);
    return (s == S_LAUNCH) || (s == S_WAIT);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage and a combinational head read, so the
// oldest entry is visible on dout_o in the same cycle it becomes valid.
module sync_fifo #(
  parameter  int WIDTH  = 8,
  parameter  int DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic [WIDTH-1:0]  din_i,
  input  logic              pop_i,
  output logic [WIDTH-1:0]  dout_o,
  output logic [ADDR_W:0]   count_o,
  output logic              full_o,
  output logic              empty_o
);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              push_ok;
  logic              pop_ok;

  assign full_o  = (count_q == (ADDR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// Queues host bytes and hands them to uart_tx one at a time, with a watchdog that
// abandons a frame whose TX_DONE never arrives.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter  int DEPTH        = 16,
  parameter  int DONE_TIMEOUT = 32,
  localparam int ADDR_W       = $clog2(DEPTH)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [7:0]        WR_DATA,
  input  logic              WR_ENA,
  output logic              WR_FULL,
  output logic [ADDR_W:0]   FIFO_COUNT,
  output logic [7:0]        TX_DIN,
  output logic              TX_ENA,
  input  logic              TX_DONE,
  output logic              BUSY,
  output logic              OVERFLOW,
  output logic              TIMEOUT
);

  localparam int              WD_W    = $clog2(DONE_TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(DONE_TIMEOUT - 1);

  tx_feeder_state_t state_q;
  logic [7:0]       tx_din_q;
  logic             tx_ena_q;
  logic [WD_W-1:0]  wd_q;
  logic             overflow_q;
  logic             timeout_q;

  logic [7:0]       fifo_head;
  logic [ADDR_W:0]  fifo_count;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;

  // Pops only happen on the cycle the FSM launches a byte out of S_IDLE.
  assign fifo_pop = (state_q == S_IDLE) && !fifo_empty;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_i   (RESET),
    .push_i  (WR_ENA),
    .din_i   (WR_DATA),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      tx_din_q   <= 8'h00;
      tx_ena_q   <= 1'b0;
      wd_q       <= '0;
      overflow_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      if (WR_ENA && fifo_full) begin
        overflow_q <= 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          if (!fifo_empty) begin
            tx_din_q <= fifo_head;
            tx_ena_q <= 1'b1;
            state_q  <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          tx_ena_q <= 1'b0;
          wd_q     <= '0;
          state_q  <= S_WAIT;
        end
        S_WAIT: begin
          // A timed-out byte is treated as sent; the next queued byte follows.
          if (TX_DONE) begin
            state_q <= S_IDLE;
          end else if (wd_q == WD_LAST) begin
            timeout_q <= 1'b1;
            state_q   <= S_IDLE;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        default: begin
          tx_ena_q <= 1'b0;
          state_q  <= S_IDLE;
        end
      endcase
    end
  end

  assign TX_DIN     = tx_din_q;
  assign TX_ENA     = tx_ena_q;
  assign OVERFLOW   = overflow_q;
  assign TIMEOUT    = timeout_q;
  assign WR_FULL    = fifo_full;
  assign FIFO_COUNT = fifo_count;
  assign BUSY       = feeder_active(state_q) || (fifo_count != '0);

endmodule
